// File: rtl/link_queue_controller.sv
// Paged multi-queue controller over an external single-port RAM.
// Free list and per-queue lists share one next_ptr table of page links.
module link_queue_controller #(
  parameter  int QID_WIDTH      = 2,
  parameter  int PAGE_NUM_LOG   = 4,
  parameter  int PAGE_WORDS_LOG = 3,
  parameter  int DATA_WIDTH     = 8,
  localparam int QUEUE_NUM      = 2**QID_WIDTH,
  localparam int PAGE_NUM       = 2**PAGE_NUM_LOG,
  localparam int ADDR_WIDTH     = PAGE_NUM_LOG+PAGE_WORDS_LOG
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_start,
  input  logic [QID_WIDTH-1:0]    wr_qid,
  input  logic                    wr_data_valid,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_data_ready,
  input  logic                    rd_start,
  input  logic [QID_WIDTH-1:0]    rd_qid,
  output logic                    rd_data_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic                    busy,
  output logic                    init_done,
  output logic [QUEUE_NUM-1:0]    q_empty,
  output logic [PAGE_NUM_LOG:0]   free_count,
  output logic                    err_wr,
  output logic                    err_rd
);
  localparam int PW = PAGE_NUM_LOG;
  localparam int WW = PAGE_WORDS_LOG;
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [PW-1:0] P_LAST = '1;
  localparam logic [WW-1:0] W_ONE  = WW'(1);
  localparam logic [WW-1:0] W_LAST = '1;
  localparam logic [PW:0]   C_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   C_FULL = (PW+1)'(PAGE_NUM);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WRITE, S_LINK, S_READ, S_FREE
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0] nxt_q   [PAGE_NUM];
  logic [PW-1:0] qhead_q [QUEUE_NUM];
  logic [PW-1:0] qtail_q [QUEUE_NUM];
  logic [PW:0]   qcnt_q  [QUEUE_NUM];
  logic [PW-1:0] fhead_q, ftail_q;
  logic [PW:0]   fcnt_q;
  logic [PW-1:0] init_q, page_q;
  logic [WW-1:0] word_q;
  logic [QID_WIDTH-1:0] qid_q;
  logic                  ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic rd_iss_q, rd_iss_last_q;
  logic rd_vld_q, rd_last_q;
  logic err_wr_q, err_rd_q, init_done_q;
  logic rd_ok, wr_ok, beat;

  assign rd_ok = rd_start && (qcnt_q[rd_qid] != '0);
  assign wr_ok = wr_start && (fcnt_q != '0);
  assign beat  = (state_q == S_WRITE) && wr_data_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:  if (init_q == P_LAST) state_d = S_IDLE;
      S_IDLE: begin
        if (rd_ok)      state_d = S_READ;
        else if (wr_ok) state_d = S_WRITE;
      end
      S_WRITE: if (beat && word_q == W_LAST) state_d = S_LINK;
      S_LINK:  state_d = S_IDLE;
      S_READ:  if (word_q == W_LAST) state_d = S_FREE;
      S_FREE:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PAGE_NUM; i++) nxt_q[i] <= '0;
      for (int i = 0; i < QUEUE_NUM; i++) begin
        qhead_q[i] <= '0;
        qtail_q[i] <= '0;
        qcnt_q[i]  <= '0;
      end
      fhead_q       <= '0;
      ftail_q       <= '0;
      fcnt_q        <= '0;
      init_q        <= '0;
      page_q        <= '0;
      word_q        <= '0;
      qid_q         <= '0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      rd_iss_q      <= 1'b0;
      rd_iss_last_q <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_last_q     <= 1'b0;
      err_wr_q      <= 1'b0;
      err_rd_q      <= 1'b0;
      init_done_q   <= 1'b0;
    end else begin
      ram_we_q      <= 1'b0;
      rd_iss_q      <= 1'b0;
      rd_iss_last_q <= 1'b0;
      rd_vld_q      <= rd_iss_q;
      rd_last_q     <= rd_iss_last_q;
      err_wr_q      <= 1'b0;
      err_rd_q      <= 1'b0;
      unique case (state_q)
        S_INIT: begin
          nxt_q[init_q] <= init_q + P_ONE;
          init_q        <= init_q + P_ONE;
          if (init_q == P_LAST) begin
            fhead_q     <= '0;
            ftail_q     <= P_LAST;
            fcnt_q      <= C_FULL;
            init_done_q <= 1'b1;
          end
        end
        S_IDLE: begin
          word_q   <= '0;
          err_rd_q <= rd_start && !rd_ok;
          err_wr_q <= wr_start && !wr_ok && !rd_ok;
          if (rd_ok) begin
            qid_q  <= rd_qid;
            page_q <= qhead_q[rd_qid];
          end else if (wr_ok) begin
            qid_q   <= wr_qid;
            page_q  <= fhead_q;
            fhead_q <= nxt_q[fhead_q];
            fcnt_q  <= fcnt_q - C_ONE;
          end
        end
        S_WRITE: begin
          if (wr_data_valid) begin
            ram_we_q    <= 1'b1;
            ram_addr_q  <= {page_q, word_q};
            ram_wdata_q <= wr_data;
            word_q      <= word_q + W_ONE;
          end
        end
        S_LINK: begin
          if (qcnt_q[qid_q] == '0) qhead_q[qid_q] <= page_q;
          else nxt_q[qtail_q[qid_q]] <= page_q;
          qtail_q[qid_q] <= page_q;
          qcnt_q[qid_q]  <= qcnt_q[qid_q] + C_ONE;
        end
        S_READ: begin
          ram_addr_q    <= {page_q, word_q};
          rd_iss_q      <= 1'b1;
          rd_iss_last_q <= (word_q == W_LAST);
          word_q        <= word_q + W_ONE;
        end
        S_FREE: begin
          qhead_q[qid_q] <= nxt_q[page_q];
          qcnt_q[qid_q]  <= qcnt_q[qid_q] - C_ONE;
          // an empty free list has a stale head, so the page becomes it
          if (fcnt_q == '0) fhead_q <= page_q;
          else nxt_q[ftail_q] <= page_q;
          ftail_q <= page_q;
          fcnt_q  <= fcnt_q + C_ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    q_empty = '0;
    for (int i = 0; i < QUEUE_NUM; i++) q_empty[i] = (qcnt_q[i] == '0);
  end

  assign busy          = (state_q != S_IDLE);
  assign wr_data_ready = (state_q == S_WRITE);
  assign rd_data_valid = rd_vld_q;
  assign rd_last       = rd_last_q;
  assign rd_data       = rd_vld_q ? ram_rdata : '0;
  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign init_done     = init_done_q;
  assign free_count    = fcnt_q;
  assign err_wr        = err_wr_q;
  assign err_rd        = err_rd_q;
endmodule

// File: doc/link_queue_controller.md
LINK_QUEUE_CONTROLLER -- requirements
Module: link_queue_controller

Interface
REQ-001 The block SHALL take these parameters: QID_WIDTH, default 2, queue-id width, QUEUE_NUM = 2**QID_WIDTH.
REQ-002 The block SHALL take PAGE_NUM_LOG, default 4, log2 of page count, PAGE_NUM = 2**PAGE_NUM_LOG.
REQ-003 The block SHALL take PAGE_WORDS_LOG, default 3, log2 of words per page, and DATA_WIDTH, default 8; ADDR_WIDTH = PAGE_NUM_LOG+PAGE_WORDS_LOG.
REQ-004 The block SHALL have ports clk in 1 clock and rst_n in 1; reset rst_n, asynchronous, active-low; clock clk.
REQ-005 The block SHALL have write-request ports wr_start in 1, page write request; wr_qid in QID_WIDTH; wr_data_valid in 1; wr_data in DATA_WIDTH; wr_data_ready out 1.
REQ-006 The block SHALL have read-request ports rd_start in 1; rd_qid in QID_WIDTH; rd_data_valid out 1; rd_data out DATA_WIDTH; rd_last out 1.
REQ-007 The block SHALL have external-RAM ports ram_we out 1; ram_addr out ADDR_WIDTH; ram_wdata out DATA_WIDTH; ram_rdata in DATA_WIDTH, valid 1 cycle after ram_addr.
REQ-008 The block SHALL have status ports busy out 1; init_done out 1; q_empty out QUEUE_NUM; free_count out PAGE_NUM_LOG+1; err_wr out 1; err_rd out 1.

Function
REQ-009 The block SHALL hold an internal next_ptr table of PAGE_NUM entries, a free list (head, tail, count) and per-queue head, tail and count[PAGE_NUM_LOG:0].
REQ-010 The FSM SHALL have states INIT, IDLE, WRITE, LINK, READ, FREE; busy SHALL be 1 in every state except IDLE.
REQ-011 INIT SHALL write next_ptr[i]=i+1 for one entry per cycle over PAGE_NUM cycles, then set free head=0, tail=PAGE_NUM-1, free_count=PAGE_NUM, enter IDLE and raise init_done.
REQ-012 wr_start and rd_start SHALL be level requests, sampled only in IDLE and consumed the cycle the FSM leaves IDLE; the requester holds them until consumed.
REQ-013 In IDLE, rd_start with q_empty[rd_qid]=0 SHALL go to READ, taking priority over any wr_start.
REQ-014 Otherwise, wr_start with free_count!=0 SHALL go to WRITE.
REQ-015 err_rd SHALL pulse for 1 cycle on rd_start in IDLE with q_empty[rd_qid]=1; err_wr SHALL pulse on wr_start in IDLE with free_count=0 when no read is taken; a rejected request SHALL cause no state change.
REQ-016 On write accept the block SHALL latch qid, take page=free head, set free head=next_ptr[page] and decrement free_count.
REQ-017 In WRITE, wr_data_ready SHALL be 1; each beat with valid&ready SHALL produce ram_we=1, ram_addr={page,word}, ram_wdata=beat on the next cycle, with the word counter incrementing from 0.
REQ-018 After beat 2**PAGE_WORDS_LOG the FSM SHALL enter LINK for 1 cycle with wr_data_ready=0.
REQ-019 LINK SHALL, for an empty queue, set head[q]=page; otherwise it SHALL set next_ptr[tail[q]]=page; it SHALL then set tail[q]=page, increment count[q] and return to IDLE.
REQ-020 On read accept the block SHALL latch qid and page=head[q].
REQ-021 READ SHALL issue ram_addr={page,word} with ram_we=0 on each of 2**PAGE_WORDS_LOG consecutive cycles, with no backpressure.
REQ-022 rd_data_valid SHALL assert 1 cycle after each read address, with rd_data=ram_rdata, and rd_last SHALL assert with the final word.
REQ-023 FREE (1 cycle) SHALL set head[q]=next_ptr[page] and decrement count[q].
REQ-024 FREE SHALL append page to the free tail: next_ptr[free tail]=page, or free head=page if free_count was 0; it SHALL then set free tail=page, increment free_count and return to IDLE.
REQ-025 Pages SHALL leave each queue in FIFO order; queues SHALL be independent; page order SHALL be preserved across next_ptr wrap-around.
REQ-026 Counters SHALL never wrap: free_count SHALL stay within 0..PAGE_NUM and count[q] within 0..PAGE_NUM.

Reset
REQ-027 On rst_n low the block SHALL force state INIT, init_done=0, busy=1, free_count=0, q_empty=all 1, and clear all queue counts.
REQ-028 On rst_n low the block SHALL drive 0 on ram_we, ram_addr, ram_wdata, wr_data_ready, rd_data_valid, rd_last, err_wr and err_rd.
REQ-029 Reset mid-operation SHALL discard any partial page and rebuild the lists via INIT.

Verification
REQ-030 The bench SHALL cover: reset release -> init_done=1 after 16 INIT cycles, free_count=16, q_empty=4'b1111.
REQ-031 The bench SHALL cover: write 0xA0..0xA7 to q2 -> ram_we at ram_addr 0..7, free_count=15, q_empty=4'b1011.
REQ-032 The bench SHALL cover: write q1 (page 0) then q2 (page 1), then read q2 -> ram_addr 8..15, rd_data in order, rd_last on 8th word, free_count=15, page 1 at free tail.
REQ-033 The bench SHALL cover: 16 page writes then wr_start -> err_wr one-cycle pulse, no ram_we, state IDLE.
REQ-034 The bench SHALL cover: rd_start on empty q3 -> err_rd pulse; rd_start q1 (non-empty) with wr_start in the same cycle -> READ taken, write accepted after FREE.
REQ-035 The bench SHALL cover: rst_n low after 3 write beats -> outputs at reset values, INIT rerun, then free_count=16, q_empty all 1.
